// File: rtl/rom_ctrl.sv
// Read-only bus slave for the AZ bus: drives a synchronous block-ROM with a
// configurable read latency and answers repeated reads from a one-entry buffer.
module rom_ctrl #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned BUF_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              err_,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                wr_q;
    logic                abort_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rdy_q;
    logic                err_q;
    logic                mem_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                buf_valid_q;
    logic [ADDR_W-1:0]   buf_addr_q;
    logic [DATA_W-1:0]   buf_data_q;

    logic req;
    logic hit;

    always_comb begin
        req   = !cs_ && !as_;
        hit   = (BUF_EN != 0) && buf_valid_q && (addr == buf_addr_q) && !flush;
        cnt_d = cnt_q - 4'd1;
    end

    // rdy_/err_ are registered out of ACK, so the strobe appears one cycle after
    // ACK is entered and the following edge samples the bus again from IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            abort_q     <= 1'b0;
            rd_data_q   <= '0;
            rdy_q       <= 1'b1;
            err_q       <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            mem_en_q <= 1'b0;
            rdy_q    <= 1'b1;
            err_q    <= 1'b1;
            if (flush) buf_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        wr_q    <= !rw;
                        abort_q <= 1'b0;
                        if (!rw) begin
                            state_q <= ACK;
                        end else if (hit) begin
                            rd_data_q <= buf_data_q;
                            state_q   <= ACK;
                        end else begin
                            mem_addr_q <= addr;
                            mem_en_q   <= 1'b1;
                            cnt_q      <= LAT;
                            state_q    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_d;
                    if (!req) abort_q <= 1'b1;
                    if (cnt_q == 4'd1) begin
                        // a completing fill overrides a flush on the same edge
                        rd_data_q   <= mem_rd_data;
                        buf_valid_q <= 1'b1;
                        if (BUF_EN != 0) begin
                            buf_addr_q <= mem_addr_q;
                            buf_data_q <= mem_rd_data;
                        end
                        state_q <= (abort_q || !req) ? IDLE : ACK;
                    end
                end
                ACK: begin
                    rdy_q   <= 1'b0;
                    err_q   <= !wr_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rdy_     = rdy_q;
    assign err_     = err_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rom_ctrl.sv
// Directed bench for rom_ctrl: a buffered 14/16-bit instance with a 3-edge ROM
// and an unbuffered 11/32-bit instance with a 1-edge ROM, sharing one bus.
module tb_rom_ctrl;

    localparam int unsigned AW = 14, DW = 16, LAT = 3;
    localparam int unsigned BAW = 11, BDW = 32, BLAT = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cs_a = 1'b1, cs_b = 1'b1, as_ = 1'b1, rw = 1'b1, flush = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic           sel = 1'b0;

    logic [DW-1:0]  rd_a, mrd_a;
    logic [AW-1:0]  maddr_a;
    logic           rdy_a, err_a, men_a;
    logic [BDW-1:0] rd_b, mrd_b;
    logic [BAW-1:0] maddr_b;
    logic           rdy_b, err_b, men_b;

    logic           rdy_m, err_m, men_m;
    logic [31:0]    data_m;

    int total = 0;
    int bad = 0;
    int rdy_lows_a = 0;
    int men_cnt_a = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom16(input logic [AW-1:0] a);
        case (a)
            14'h0050: return 16'h0550;
            14'h0123: return 16'hBEEF;
            14'h0001: return 16'h1111;
            14'h3FFF: return 16'hFFEE;
            14'h07FF: return 16'h7FF7;
            default:  return 16'hDEAD;
        endcase
    endfunction

    function automatic logic [BDW-1:0] rom32(input logic [BAW-1:0] a);
        return (a == 11'h123) ? 32'hDEADBEEF : 32'h0BAD0BAD;
    endfunction

    assign mrd_a = rom16(maddr_a);
    assign mrd_b = rom32(maddr_b);

    always_comb begin
        rdy_m  = sel ? rdy_b : rdy_a;
        err_m  = sel ? err_b : err_a;
        men_m  = sel ? men_b : men_a;
        data_m = sel ? rd_b : {16'h0, rd_a};
    end

    always @(negedge clk) begin
        if (!rdy_a) rdy_lows_a++;
        if (men_a)  men_cnt_a++;
    end

    rom_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .BUF_EN(1)) u_buf (
        .clk(clk), .reset(reset), .cs_(cs_a), .as_(as_), .rw(rw), .addr(addr),
        .flush(flush), .rd_data(rd_a), .rdy_(rdy_a), .err_(err_a), .mem_en(men_a),
        .mem_addr(maddr_a), .mem_rd_data(mrd_a)
    );

    rom_ctrl #(.ADDR_W(BAW), .DATA_W(BDW), .MEM_LAT(BLAT), .BUF_EN(0)) u_nobuf (
        .clk(clk), .reset(reset), .cs_(cs_b), .as_(as_), .rw(rw), .addr(addr[BAW-1:0]),
        .flush(flush), .rd_data(rd_b), .rdy_(rdy_b), .err_(err_b), .mem_en(men_b),
        .mem_addr(maddr_b), .mem_rd_data(mrd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One bus transaction; lat counts edges from the sampling edge to rdy_ low.
    task automatic txn(input logic sel_i, input logic wr, input logic [AW-1:0] a,
                       input logic fl_same, output int lat, output int men,
                       output logic [31:0] data, output logic err, output logic rdy_after);
        @(negedge clk);
        sel = sel_i;
        if (sel_i) cs_b = 1'b0; else cs_a = 1'b0;
        as_ = 1'b0; rw = !wr; addr = a; flush = fl_same;
        lat = -1; men = 0; data = '0; err = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (men_m) men++;
            if (!rdy_m) begin
                lat = k; data = data_m; err = err_m;
                break;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        cs_a = 1'b1; cs_b = 1'b1; as_ = 1'b1;
        @(posedge clk); #1;
        rdy_after = rdy_m;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        int            fl;   // 0 none, 1 standalone pulse before, 2 with the request
        int            lat;
        int            men;
        logic          err;
        logic [31:0]   data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int          lat, men, lows0, mens0, pulses;
        logic [31:0] data;
        logic [31:0] got[2];
        logic        err, rdy_after;

        vecs[0]  = '{1'b0, 14'h0123, 0, 4, 1, 1'b1, 32'hBEEF};
        vecs[1]  = '{1'b0, 14'h0123, 0, 1, 0, 1'b1, 32'hBEEF};
        vecs[2]  = '{1'b1, 14'h0010, 0, 1, 0, 1'b0, 32'hBEEF};
        vecs[3]  = '{1'b0, 14'h0123, 0, 1, 0, 1'b1, 32'hBEEF};
        vecs[4]  = '{1'b0, 14'h0123, 2, 4, 1, 1'b1, 32'hBEEF};
        vecs[5]  = '{1'b0, 14'h0123, 0, 1, 0, 1'b1, 32'hBEEF};
        vecs[6]  = '{1'b0, 14'h0123, 1, 4, 1, 1'b1, 32'hBEEF};
        vecs[7]  = '{1'b0, 14'h0001, 0, 4, 1, 1'b1, 32'h1111};
        vecs[8]  = '{1'b0, 14'h0123, 0, 4, 1, 1'b1, 32'hBEEF};
        vecs[9]  = '{1'b0, 14'h3FFF, 0, 4, 1, 1'b1, 32'hFFEE};
        vecs[10] = '{1'b0, 14'h3FFF, 0, 1, 0, 1'b1, 32'hFFEE};
        vecs[11] = '{1'b1, 14'h3FFF, 0, 1, 0, 1'b0, 32'hFFEE};
        vecs[12] = '{1'b0, 14'h3FFF, 0, 1, 0, 1'b1, 32'hFFEE};

        #12;
        check("rst_rdy", {31'h0, rdy_a}, 32'h1);
        check("rst_err", {31'h0, err_a}, 32'h1);
        check("rst_men", {31'h0, men_a}, 32'h0);
        check("rst_maddr", {18'h0, maddr_a}, 32'h0);
        check("rst_rd", {16'h0, rd_a}, 32'h0);
        check("rst_b_rdy", {31'h0, rdy_b}, 32'h1);
        check("rst_b_rd", rd_b, 32'h0);
        @(negedge clk); reset = 1'b1;

        // fill the buffer, then reset in the middle of another miss
        txn(1'b0, 1'b0, 14'h0050, 1'b0, lat, men, data, err, rdy_after);
        check("pre_lat", 32'(lat), 32'd4);
        check("pre_data", data, 32'h0550);
        @(negedge clk);
        sel = 1'b0; cs_a = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 14'h0123;
        lows0 = rdy_lows_a;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0; #1;
        check("mid_rdy", {31'h0, rdy_a}, 32'h1);
        check("mid_err", {31'h0, err_a}, 32'h1);
        check("mid_men", {31'h0, men_a}, 32'h0);
        check("mid_maddr", {18'h0, maddr_a}, 32'h0);
        check("mid_rd", {16'h0, rd_a}, 32'h0);
        @(negedge clk); cs_a = 1'b1; as_ = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_no_rdy", 32'(rdy_lows_a - lows0), 32'd0);
        txn(1'b0, 1'b0, 14'h0050, 1'b0, lat, men, data, err, rdy_after);
        check("post_rst_lat", 32'(lat), 32'd4);
        check("post_rst_men", 32'(men), 32'd1);
        check("post_rst_data", data, 32'h0550);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].fl == 1) begin
                @(negedge clk); flush = 1'b1;
                @(negedge clk); flush = 1'b0;
            end
            txn(1'b0, vecs[i].wr, vecs[i].a, vecs[i].fl == 2, lat, men, data, err, rdy_after);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_men", i), 32'(men), 32'(vecs[i].men));
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_data", i), data, vecs[i].data);
            check($sformatf("v%0d_pulse", i), {31'h0, rdy_after}, 32'h1);
        end

        // abort: strobe dropped while the ROM access is in flight
        @(negedge clk);
        sel = 1'b0; cs_a = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 14'h07FF;
        lows0 = rdy_lows_a; mens0 = men_cnt_a;
        @(posedge clk); @(posedge clk);
        @(negedge clk); cs_a = 1'b1; as_ = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_rdy", 32'(rdy_lows_a - lows0), 32'd0);
        check("abort_men", 32'(men_cnt_a - mens0), 32'd1);
        txn(1'b0, 1'b0, 14'h07FF, 1'b0, lat, men, data, err, rdy_after);
        check("abort_hit_lat", 32'(lat), 32'd1);
        check("abort_hit_men", 32'(men), 32'd0);
        check("abort_hit_data", data, 32'h7FF7);

        // back-to-back: strobe held, address swapped after the first rdy_
        @(negedge clk);
        sel = 1'b0; cs_a = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 14'h0001;
        lows0 = rdy_lows_a; pulses = 0; got[0] = '0; got[1] = '0;
        for (int k = 0; k < 40 && pulses < 2; k++) begin
            @(posedge clk); #1;
            if (!rdy_a) begin
                got[pulses] = {16'h0, rd_a};
                pulses++;
                @(negedge clk);
                if (pulses == 1) addr = 14'h3FFF;
                else begin cs_a = 1'b1; as_ = 1'b1; end
            end
        end
        cs_a = 1'b1; as_ = 1'b1;
        repeat (4) @(negedge clk);
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_low_cycles", 32'(rdy_lows_a - lows0), 32'd2);
        check("b2b_data0", got[0], 32'h1111);
        check("b2b_data1", got[1], 32'hFFEE);

        // unbuffered instance: every read misses, latency MEM_LAT+1
        for (int r = 0; r < 2; r++) begin
            txn(1'b1, 1'b0, 14'h0123, 1'b0, lat, men, data, err, rdy_after);
            check($sformatf("nb%0d_lat", r), 32'(lat), 32'd2);
            check($sformatf("nb%0d_men", r), 32'(men), 32'd1);
            check($sformatf("nb%0d_data", r), data, 32'hDEADBEEF);
            check($sformatf("nb%0d_pulse", r), {31'h0, rdy_after}, 32'h1);
        end
        txn(1'b1, 1'b1, 14'h0010, 1'b0, lat, men, data, err, rdy_after);
        check("nb_wr_lat", 32'(lat), 32'd1);
        check("nb_wr_err", {31'h0, err}, 32'h0);
        check("nb_wr_data", data, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
